register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp.sv | 140 ++++++++++++++
 tb/tb_register_file_mp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port register file. It has NUM_WR_PORTS synchronous write ports and
//   NUM_RD_PORTS combinational read ports. Register 0 always reads as zero.
//   The storage array has no reset. After reset, or on a clr_req pulse, a
//   CLEAR sequence zeroes registers 1..NUM_REGS-1, one per clock edge. Reads
//   return zero and writes are dropped until the FSM reaches READY.
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   clr_req     : start a full clear (sampled in READY only)
//   ready       : 1 when writes are accepted and reads are valid
//   wr_en/wr_reg/wr_data : packed per-port write controls, port p at [p*W +: W]
//   rd_reg/rd_data       : packed per-port read address / data
//   wr_collide  : two or more enabled write ports hit the same non-zero register
module register_file_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int BYPASS       = 1,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr_req,
  output logic                               ready,
  input  logic [NUM_WR_PORTS-1:0]            wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]         wr_reg,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]         rd_reg,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic                               wr_collide
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic            wr_active;

  // A write is taken only in READY with no clear request. The rst_n term
  // drops a write whose edge coincides with reset being asserted.
  assign wr_active = (state_q == READY) && !clr_req && rst_n;
  assign ready     = ready_q;

  // FSM next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + FIRST_IDX;
      if (clr_idx_q == LAST_IDX) begin
        state_d   = READY;
        clr_idx_d = FIRST_IDX;
      end
    end else if (clr_req) begin
      state_d   = CLEAR;
      clr_idx_d = FIRST_IDX;
    end
    ready_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= FIRST_IDX;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage next value. Ports are applied in ascending order, so the
  // highest-indexed port wins on a shared address.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clr_idx_q] = '0;
    end else if (wr_active) begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_en[p] && (wr_reg[p*AW +: AW] != '0)) begin
          regs_d[wr_reg[p*AW +: AW]] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // The storage array has no reset. The clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= regs_d;
    end
  end

  // Collision detect is purely combinational and is valid in any state.
  always_comb begin
    wr_collide = 1'b0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      for (int q = p + 1; q < NUM_WR_PORTS; q++) begin
        if (wr_en[p] && wr_en[q] &&
            (wr_reg[p*AW +: AW] == wr_reg[q*AW +: AW]) &&
            (wr_reg[p*AW +: AW] != '0)) begin
          wr_collide = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic [AW-1:0]         addr;
      logic [DATA_WIDTH-1:0] val;
      always_comb begin
        addr = rd_reg[gi*AW +: AW];
        val  = regs_q[addr];
        if ((BYPASS != 0) && wr_active) begin
          for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p] && (wr_reg[p*AW +: AW] == addr)) begin
              val = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        // Register 0 and every read while not ready return zero.
        if (!ready_q || (addr == '0)) begin
          val = '0;
        end
      end
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = val;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_req;
  logic        ready;
  logic [1:0]  wr_en;
  logic [9:0]  wr_reg;
  logic [63:0] wr_data;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic        wr_collide;

  int errors = 0;
  int checks = 0;

  register_file_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .wr_collide(wr_collide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a clear that has already started and checks its length.
  // ready must stay low for 30 edges and go high on edge 31.
  task automatic clear_len(input string tag);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk({tag, "_busy"}, {63'd0, ready}, 64'd0);
    end
    tick();
    chk({tag, "_done"}, {63'd0, ready}, 64'd1);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_reg = {5'(31 - i), 5'(i)};
      #1;
      chk(tag, rd_data, 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; wr_en = '0; wr_reg = '0; wr_data = '0; rd_reg = '0;
    tick();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Power-up clear
    clear_len("init_clear");
    all_zero("init_zero");

    // Two ports write different registers in the same cycle
    wr_en = 2'b11; wr_reg = {5'd9, 5'd5}; wr_data = {32'h12345678, 32'hDEADBEEF};
    #1;
    chk("no_collide_diff", {63'd0, wr_collide}, 64'd0);
    tick();
    wr_en = 2'b00; rd_reg = {5'd9, 5'd5};
    #1;
    chk("rd_5_9", rd_data, {32'h12345678, 32'hDEADBEEF});

    // Both ports write reg 7; port 1 wins, and the same-cycle read bypasses
    wr_en = 2'b11; wr_reg = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111}; rd_reg = {5'd5, 5'd7};
    #1;
    chk("collide_7", {63'd0, wr_collide}, 64'd1);
    chk("bypass_7", rd_data, {32'hDEADBEEF, 32'h2222});
    tick();
    wr_en = 2'b00;
    #1;
    chk("collide_clr", {63'd0, wr_collide}, 64'd0);
    chk("stored_7", rd_data, {32'hDEADBEEF, 32'h2222});

    // Writes to register 0 never collide and never stick
    wr_en = 2'b11; wr_reg = '0; wr_data = {2{32'hFFFFFFFF}}; rd_reg = '0;
    #1;
    chk("collide_r0", {63'd0, wr_collide}, 64'd0);
    chk("bypass_r0", rd_data, 64'd0);
    tick();
    wr_en = 2'b00;
    #1;
    chk("stored_r0", rd_data, 64'd0);

    // Fill 1..31, then clear with a concurrent write to reg 3
    for (int i = 1; i < 32; i++) begin
      wr_en = 2'b01; wr_reg = {5'd0, 5'(i)}; wr_data = {32'd0, 32'hA5A5A5A5};
      tick();
    end
    wr_en = 2'b00; rd_reg = {5'd31, 5'd3};
    #1;
    chk("fill_3_31", rd_data, {2{32'hA5A5A5A5}});
    clr_req = 1'b1; wr_en = 2'b01; wr_reg = {5'd0, 5'd3}; wr_data = {32'd0, 32'h77777777};
    #1;
    chk("no_bypass_clr", rd_data, {2{32'hA5A5A5A5}});
    tick();
    wr_en = 2'b00;
    chk("clr_entered", {63'd0, ready}, 64'd0);
    chk("clr_rd_zero", rd_data, 64'd0);
    // clr_req stays high for the first few clear edges. It must be ignored
    // there, and it is dropped before READY.
    for (int i = 1; i <= 30; i++) begin
      if (i == 6) clr_req = 1'b0;
      tick();
      chk("clr_busy", {63'd0, ready}, 64'd0);
    end
    tick();
    chk("clr_done", {63'd0, ready}, 64'd1);
    all_zero("clr_zero");

    // Reset asserted mid-clear at clr_idx=10
    wr_en = 2'b01; wr_reg = {5'd0, 5'd4}; wr_data = {32'd0, 32'h44444444};
    tick();
    wr_en = 2'b00; clr_req = 1'b1;
    tick();                              // CLEAR, clr_idx=1
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();  // clr_idx=10
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_rd", rd_data, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_len("rst_clear");
    all_zero("rst_zero");

    // Reset asserted mid-write in READY forces reads to zero immediately
    wr_en = 2'b01; wr_reg = {5'd0, 5'd4}; wr_data = {32'd0, 32'h44444444};
    tick();
    wr_en = 2'b01; wr_reg = {5'd0, 5'd6}; wr_data = {32'd0, 32'h66666666}; rd_reg = {5'd6, 5'd4};
    #1;
    chk("pre_rst_rd", rd_data, {32'h66666666, 32'h44444444});
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", {63'd0, ready}, 64'd0);
    chk("rst_wr_rd", rd_data, 64'd0);
    tick();
    wr_en = 2'b00;
    rst_n = 1'b1;
    clear_len("rst2_clear");
    rd_reg = {5'd6, 5'd4};
    #1;
    chk("rst2_zero", rd_data, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
